inst_fetch_unit: RTL

//  Instruction-fetch sequencer for the multi-cycle microprogrammed CPU: the writer side of the instruction register.
//  On a fetch command from the microprogram controller it reads one 32-bit word from instruction memory

---
 rtl/inst_fetch_unit_pkg.sv | 18 +
 rtl/inst_fetch_unit_wdog.sv | 28 ++
 rtl/inst_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding, widths, reset PC.
package inst_fetch_unit_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StLoad = 2'd2
    } fetch_state_e;

    // Branch/jump targets are forced onto a word boundary.
    function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] addr);
        return {addr[INST_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_wdog.sv
// Bus-timeout watchdog: counts enabled cycles, flags expiry on the TIMEOUT-th one.
module inst_fetch_unit_wdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q;

    // Expiry is seen during the last allowed cycle so the owner can leave on that edge.
    assign expire = en && (cnt_q == CntW'(TIMEOUT - 1));

    // Cycle counter; saturates at expiry, cleared whenever the owner restarts it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, fetches one word per request over req/ack
// and writes it to the IR with a one-cycle strobe.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_w,
    output logic [31:0] ir_d,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc,
    output logic        busy,
    output logic        bus_err,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic         mem_req_q, mem_req_d;
    logic         ir_w_q, ir_w_d;
    logic         busy_q, busy_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  ir_d_q, ir_d_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         bus_err_q, bus_err_d;
    logic         misalign_q, misalign_d;
    logic         wdog_expire, wdog_restart;
    logic [31:0]  redir_tgt;
    logic         redirect_hit;

    assign redir_tgt    = align_word(redirect_pc);
    // A redirect seen this cycle or earlier in the fetch invalidates the returning word.
    assign redirect_hit = pend_q || redirect_valid;

    inst_fetch_unit_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state_q != StReq) || wdog_restart),
        .en    (state_q == StReq),
        .expire(wdog_expire)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (fetch_start) state_d = StReq;
            StReq: begin
                if (mem_ack) begin
                    if (!redirect_hit) state_d = StLoad;
                end else if (wdog_expire) begin
                    state_d = StIdle;
                end
            end
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, computed from the next state so they can be registered.
    always_comb begin
        mem_req_d = (state_d == StReq);
        ir_w_d    = (state_d == StLoad);
        busy_d    = (state_d != StIdle);
    end

    // Datapath next-state: PC, pending redirect, IR data and sticky flags.
    always_comb begin
        pc_d         = pc_q;
        inst_pc_d    = inst_pc_q;
        ir_d_d       = ir_d_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        bus_err_d    = bus_err_q;
        misalign_d   = misalign_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
        wdog_restart = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (redirect_valid) pc_d = redir_tgt;
                if (fetch_start) bus_err_d = 1'b0;
            end
            StReq: begin
                if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redir_tgt;
                end
                if (mem_ack) begin
                    if (redirect_hit) begin
                        // Drop the stale word and refetch from the newest target.
                        pc_d         = redirect_valid ? redir_tgt : pend_pc_q;
                        pend_d       = 1'b0;
                        wdog_restart = 1'b1;
                    end else begin
                        ir_d_d    = mem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + 32'(PC_STEP);
                    end
                end else if (wdog_expire) begin
                    bus_err_d = 1'b1;
                    // A branch requested during the failed fetch must not be lost.
                    if (redirect_hit) begin
                        pc_d   = redirect_valid ? redir_tgt : pend_pc_q;
                        pend_d = 1'b0;
                    end
                end
            end
            StLoad: if (redirect_valid) pc_d = redir_tgt;
            default: ;
        endcase
    end

    // Datapath and registered-output state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q  <= 1'b0;
            ir_w_q     <= 1'b0;
            busy_q     <= 1'b0;
            pc_q       <= RESET_PC;
            inst_pc_q  <= RESET_PC;
            ir_d_q     <= '0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            mem_req_q  <= mem_req_d;
            ir_w_q     <= ir_w_d;
            busy_q     <= busy_d;
            pc_q       <= pc_d;
            inst_pc_q  <= inst_pc_d;
            ir_d_q     <= ir_d_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = pc_q;
    assign ir_w     = ir_w_q;
    assign ir_d     = ir_d_q;
    assign inst_pc  = inst_pc_q;
    assign pc_plus4 = inst_pc_q + 32'(PC_STEP);
    assign pc       = pc_q;
    assign busy     = busy_q;
    assign bus_err  = bus_err_q;
    assign misalign = misalign_q;

endmodule
